// File: rtl/xor_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : xor_frame_sequencer
//  Purpose  : Buffers a framed UART request (N, data, K, key), XOR-encrypts it
//             one byte per cycle and streams length + ciphertext back out.
//  Revision : 1.0  initial release
// ============================================================================
module xor_frame_sequencer #(
   parameter int MAX_DATA = 100,
   parameter int MAX_KEY  = 4
) (
   input  logic       Clk_100M,
   input  logic       Reset,
   input  logic [7:0] Rx_Data,
   input  logic       Rx_Ready,
   output logic       Rx_Ack,
   output logic [7:0] Tx_Data,
   output logic       Tx_Send,
   input  logic       Tx_Busy,
   input  logic [7:0] view_index,
   output logic [7:0] view_plain,
   output logic [7:0] view_cipher,
   output logic [7:0] data_len,
   output logic       busy,
   output logic       done
);

   localparam int         c_dataIdxW = (MAX_DATA > 1) ? $clog2(MAX_DATA) : 1;
   localparam int         c_keyIdxW  = (MAX_KEY > 1) ? $clog2(MAX_KEY) : 1;
   localparam logic [7:0] c_maxData  = 8'(MAX_DATA);
   localparam logic [7:0] c_maxKey   = 8'(MAX_KEY);

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_RX_DATA = 4'd1,
      ST_RX_KLEN = 4'd2,
      ST_RX_KEY  = 4'd3,
      ST_ENC     = 4'd4,
      ST_TX_LEN  = 4'd5,
      ST_TX_DATA = 4'd6,
      ST_DONE    = 4'd7
   } state_t;

   state_t     r_state;
   state_t     w_nextState;

   logic       r_rxAck;
   logic [7:0] r_nRaw;
   logic [7:0] r_kRaw;
   logic [7:0] r_rxCount;
   logic [7:0] r_dataLen;
   logic [7:0] r_keyLen;
   logic [7:0] r_encIdx;
   logic [7:0] r_keyIdx;
   logic [7:0] r_txIdx;
   logic [1:0] r_txPhase;
   logic       r_txSend;
   logic [7:0] r_txData;
   logic [7:0] r_viewPlain;
   logic [7:0] r_viewCipher;

   logic [7:0] r_dataMem   [MAX_DATA];
   logic [7:0] r_cipherMem [MAX_DATA];
   logic [7:0] r_keyMem    [MAX_KEY];

   logic       w_rxOpen;
   logic       w_take;
   logic       w_txDone;
   logic [7:0] w_dataClamp;
   logic [7:0] w_keyClamp;
   logic [7:0] w_txByte;
   logic [7:0] w_cipherByte;

   always_comb begin
      w_rxOpen     = (r_state == ST_IDLE) || (r_state == ST_RX_DATA) ||
                     (r_state == ST_RX_KLEN) || (r_state == ST_RX_KEY) ||
                     (r_state == ST_DONE);
      w_take       = w_rxOpen && Rx_Ready && !r_rxAck;
      w_txDone     = (r_txPhase == 2'd2) && !Tx_Busy;
      w_dataClamp  = (Rx_Data > c_maxData) ? c_maxData : Rx_Data;
      w_keyClamp   = (Rx_Data > c_maxKey) ? c_maxKey : Rx_Data;
      w_txByte     = (r_state == ST_TX_LEN) ? r_dataLen
                                            : r_cipherMem[r_txIdx[c_dataIdxW-1:0]];
      w_cipherByte = r_dataMem[r_encIdx[c_dataIdxW-1:0]] ^
                     r_keyMem[r_keyIdx[c_keyIdxW-1:0]];

      w_nextState = r_state;
      case (r_state)
         ST_IDLE, ST_DONE:
            if (w_take && Rx_Data != 8'd0) w_nextState = ST_RX_DATA;
         ST_RX_DATA:
            if (w_take && r_rxCount == r_nRaw - 8'd1) w_nextState = ST_RX_KLEN;
         ST_RX_KLEN:
            if (w_take) w_nextState = (Rx_Data == 8'd0) ? ST_ENC : ST_RX_KEY;
         ST_RX_KEY:
            if (w_take && r_rxCount == r_kRaw - 8'd1) w_nextState = ST_ENC;
         ST_ENC:
            if (r_encIdx == r_dataLen - 8'd1) w_nextState = ST_TX_LEN;
         ST_TX_LEN:
            if (w_txDone) w_nextState = ST_TX_DATA;
         ST_TX_DATA:
            if (w_txDone && r_txIdx == r_dataLen - 8'd1) w_nextState = ST_DONE;
         default:
            w_nextState = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk_100M) begin
      if (Reset) r_state <= ST_IDLE;
      else       r_state <= w_nextState;
   end

   // Counters track raw N/K so oversize frames are still consumed in full.
   always_ff @(posedge Clk_100M) begin
      if (Reset) begin
         r_rxAck      <= 1'b0;
         r_nRaw       <= 8'd0;
         r_kRaw       <= 8'd0;
         r_rxCount    <= 8'd0;
         r_dataLen    <= 8'd0;
         r_keyLen     <= 8'd0;
         r_encIdx     <= 8'd0;
         r_keyIdx     <= 8'd0;
         r_txIdx      <= 8'd0;
         r_txPhase    <= 2'd0;
         r_txSend     <= 1'b0;
         r_txData     <= 8'd0;
         r_viewPlain  <= 8'd0;
         r_viewCipher <= 8'd0;
      end else begin
         r_txSend <= 1'b0;

         if (w_take)         r_rxAck <= 1'b1;
         else if (!Rx_Ready) r_rxAck <= 1'b0;

         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (w_take && Rx_Data != 8'd0) begin
                  r_nRaw    <= Rx_Data;
                  r_dataLen <= w_dataClamp;
                  r_rxCount <= 8'd0;
               end
            end
            ST_RX_DATA: begin
               if (w_take)
                  r_rxCount <= (r_rxCount == r_nRaw - 8'd1) ? 8'd0 : r_rxCount + 8'd1;
            end
            ST_RX_KLEN: begin
               if (w_take) begin
                  r_rxCount <= 8'd0;
                  r_kRaw    <= Rx_Data;
                  r_keyLen  <= (Rx_Data == 8'd0) ? 8'd1 : w_keyClamp;
                  r_encIdx  <= 8'd0;
                  r_keyIdx  <= 8'd0;
                  r_txIdx   <= 8'd0;
                  r_txPhase <= 2'd0;
               end
            end
            ST_RX_KEY: begin
               if (w_take) r_rxCount <= r_rxCount + 8'd1;
            end
            ST_ENC: begin
               r_encIdx <= r_encIdx + 8'd1;
               r_keyIdx <= (r_keyIdx == r_keyLen - 8'd1) ? 8'd0 : r_keyIdx + 8'd1;
            end
            ST_TX_LEN, ST_TX_DATA: begin
               case (r_txPhase)
                  2'd0: begin
                     if (!Tx_Busy) begin
                        r_txSend  <= 1'b1;
                        r_txData  <= w_txByte;
                        r_txPhase <= 2'd1;
                     end
                  end
                  2'd1: begin
                     if (Tx_Busy) r_txPhase <= 2'd2;
                  end
                  default: begin
                     if (!Tx_Busy) begin
                        r_txPhase <= 2'd0;
                        if (r_state == ST_TX_DATA) r_txIdx <= r_txIdx + 8'd1;
                     end
                  end
               endcase
            end
            default: ;
         endcase

         r_viewPlain  <= (view_index < r_dataLen) ? r_dataMem[view_index[c_dataIdxW-1:0]]   : 8'h00;
         r_viewCipher <= (view_index < r_dataLen) ? r_cipherMem[view_index[c_dataIdxW-1:0]] : 8'h00;
      end
   end

   // Buffer contents deliberately survive reset; data_len gates visibility.
   always_ff @(posedge Clk_100M) begin
      if (!Reset) begin
         if (w_take && r_state == ST_RX_DATA && r_rxCount < c_maxData)
            r_dataMem[r_rxCount[c_dataIdxW-1:0]] <= Rx_Data;
         if (w_take && r_state == ST_RX_KLEN && Rx_Data == 8'd0)
            r_keyMem[0] <= 8'h00;
         if (w_take && r_state == ST_RX_KEY && r_rxCount < r_keyLen)
            r_keyMem[r_rxCount[c_keyIdxW-1:0]] <= Rx_Data;
         if (r_state == ST_ENC)
            r_cipherMem[r_encIdx[c_dataIdxW-1:0]] <= w_cipherByte;
      end
   end

   assign Rx_Ack      = r_rxAck;
   assign Tx_Data     = r_txData;
   assign Tx_Send     = r_txSend;
   assign view_plain  = r_viewPlain;
   assign view_cipher = r_viewCipher;
   assign data_len    = r_dataLen;
   assign busy        = (r_state != ST_IDLE) && (r_state != ST_DONE);
   assign done        = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: doc/xor_frame_sequencer.md
# xor_frame_sequencer

Controller for the XOR byte-cipher datapath on the 100 MHz board design. It accepts a framed request from the UART receiver and buffers the data and key bytes. It then encrypts each byte as `data[i] ^ key[i mod key_len]`, one byte per cycle, and returns the result to the PC through the UART sender. It also exposes a read port so the LED display logic can browse the plaintext and ciphertext buffers by index.

## Interface
Parameters:
- MAX_DATA, 100: data buffer depth in bytes.
- MAX_KEY, 4: key buffer depth in bytes.

Ports (`name direction width meaning`):
- Clk_100M in 1: the single clock.
- Reset in 1: synchronous, active-high reset.
- Rx_Data in 8: received byte; valid while Rx_Ready is high.
- Rx_Ready in 1: receiver holds a byte.
- Rx_Ack out 1: byte consumed; held high until Rx_Ready falls.
- Tx_Data out 8: byte to transmit.
- Tx_Send out 1: one-cycle send strobe.
- Tx_Busy in 1: sender is shifting a byte out.
- view_index in 8: display browse index.
- view_plain out 8: `data[view_index]`, or 0 if view_index ≥ data_len.
- view_cipher out 8: `cipher[view_index]`, or 0 if view_index ≥ data_len.
- data_len out 8: stored data length.
- busy out 1: high in every state except IDLE and DONE.
- done out 1: high in DONE.

## Operation
Frame format, one byte at a time: N, then N data bytes, then K, then K key bytes.

States and transitions:
- IDLE: wait for a byte.
  - Byte 0: ignored; stay in IDLE.
  - Otherwise: set `data_len = min(N, MAX_DATA)`, keep the raw N for counting, go to RX_DATA.
- RX_DATA: store byte `i` while `i < MAX_DATA`; discard the rest.
  - After N bytes: go to RX_KLEN.
- RX_KLEN: handle the key length K.
  - K = 0: set `key_len = 1` and `key[0] = 0x00`, go to ENC.
  - Otherwise: set `key_len = min(K, MAX_KEY)`, go to RX_KEY.
- RX_KEY: store the first key_len bytes; discard the rest.
  - After K bytes: go to ENC.
- ENC: one byte per cycle, `cipher[i] = data[i] ^ key[k]`.
  - k wraps to 0 when it reaches key_len (no modulo operator).
  - After data_len cycles: go to TX_LEN.
- TX_LEN: transmit data_len, go to TX_DATA.
- TX_DATA: transmit `cipher[0..data_len-1]` in order, go to DONE.
- DONE: results stay readable.
  - A new byte with Rx_Ready high is handled exactly as in IDLE; a non-zero byte starts a new frame.

Rx handshake:
- A byte is taken on the first cycle where Rx_Ready is high and Rx_Ack is low.
- Rx_Ack rises the next cycle and stays high while Rx_Ready is high.
- Rx_Ack falls the cycle after Rx_Ready is seen low.
- Exactly one byte is consumed per Rx_Ready pulse.
- Rx bytes arriving in ENC, TX_LEN or TX_DATA are not acknowledged.
  - Rx_Ack stays low; the byte waits in the receiver.

Tx handshake, per byte:
- Wait for Tx_Busy low.
- Drive Tx_Data and pulse Tx_Send for 1 cycle.
- Wait for Tx_Busy high, then wait for Tx_Busy low.
- Tx_Data is held stable from the strobe until Tx_Busy rises.

Width and boundary rules:
- All counters are 8 bits; lengths are 1..255.
- Clamping applies only to storage. The counts of consumed bytes always equal N and K, so the frame stays aligned.
- data_len equal to MAX_DATA is a legal full buffer; no overflow write.
- view_index at or beyond data_len returns 0x00 on both view outputs.

## Timing
- Reset values:
  - Rx_Ack 0, Tx_Send 0, Tx_Data 0x00.
  - data_len 0, busy 0, done 0.
  - State IDLE; all counters 0.
  - Buffer contents are not cleared. The view outputs read 0 because data_len is 0.
- Reset wins over every other event, including reset in the middle of a frame or in the middle of a Tx byte.
  - Tx_Send is low on the cycle after Reset.
- ENC latency: exactly data_len cycles.
  - The TX_LEN strobe no earlier than 1 cycle after the last cipher write.
- view_plain and view_cipher are registered: 1-cycle latency from view_index.
  - A write in the same cycle as a read returns the old value.
- Rx_Ack and the state update on the same clock edge the byte is taken.
- done rises in the cycle after the last Tx_Busy falling edge.

## Test plan
- N=3 "ABC", K=2 {0x01,0x02}:
  - cipher {0x40,0x40,0x42}.
  - Tx sequence 0x03,0x40,0x40,0x42.
  - done=1; view_cipher[2]=0x42.
- Leading 0x00 then N=1 {0x55}, K=1 {0xFF}:
  - the 0x00 is ignored.
  - Tx sequence 0x01,0xAA.
- N=MAX_DATA+2 (102) with data = index, K=5 {1,2,3,4,5}:
  - data_len=100, key_len=4.
  - cipher[4]=0x04^0x01=0x05.
  - Tx sends 100 then 100 bytes; the 2 extra data bytes and 1 extra key byte are consumed without misaligning the frame.
- K=0:
  - cipher equals plaintext.
  - Rx_Ready arriving during TX_DATA sees Rx_Ack stay low until DONE.
- Reset asserted mid-RX_DATA and again mid-TX_DATA:
  - next cycle Rx_Ack=0, Tx_Send=0, data_len=0, view outputs 0x00.
  - A fresh full frame then completes correctly.
- Tx_Busy held high for 50 cycles per byte:
  - exactly one Tx_Send per byte.
  - Tx_Data stable until Tx_Busy rises; no byte dropped or duplicated.
